// File: rtl/machina_pkg.sv
// Shared widths for the neural datapath blocks.
package machina_pkg;
  localparam int DEF_ARGW = 16;
  localparam int DEF_RESW = 8;
  localparam int DEF_ERRW = 16;
  localparam int DEF_FBKW = 16;
endpackage

// File: rtl/heaviside_unit_skid_reg.sv
// Single-entry valid/ready output register that refills on the same edge it drains.
module skid_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         in_stb,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_stb,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  logic load;

  assign in_rdy = enable && (!out_stb || out_rdy);
  assign load   = in_stb && in_rdy;

  // A new load wins over a drain on the same edge, keeping throughput at one per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_stb <= 1'b0;
      out_dat <= '0;
    end else if (load) begin
      out_stb <= 1'b1;
      out_dat <= in_dat;
    end else if (out_rdy) begin
      out_stb <= 1'b0;
    end
  end

endmodule

// File: rtl/heaviside_unit.sv
// Heaviside step activation: thresholded forward pass and straight-through backward pass.
module heaviside_unit
  import machina_pkg::*;
#(
  parameter int ARGW = DEF_ARGW,
  parameter int RESW = DEF_RESW,
  parameter int ERRW = DEF_ERRW,
  parameter int FBKW = DEF_FBKW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            en,
  input  logic            arg_stb,
  input  logic [ARGW-1:0] arg_dat,
  output logic            arg_rdy,
  output logic            res_stb,
  output logic [RESW-1:0] res_dat,
  input  logic            res_rdy,
  input  logic            err_stb,
  input  logic [ERRW-1:0] err_dat,
  output logic            err_rdy,
  output logic            fbk_stb,
  output logic [FBKW-1:0] fbk_dat,
  input  logic            fbk_rdy
);

  logic [RESW-1:0] step_val;
  logic [FBKW-1:0] fbk_ext;
  logic            fbk_in_rdy;

  // Zero counts as "on", so only a set sign bit turns the output off.
  assign step_val = ($signed(arg_dat) >= $signed(ARGW'(0))) ? '1 : '0;
  assign fbk_ext  = FBKW'($signed(err_dat));

  skid_reg #(.W(RESW)) u_res (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .in_stb  (arg_stb),
    .in_dat  (step_val),
    .in_rdy  (arg_rdy),
    .out_stb (res_stb),
    .out_dat (res_dat),
    .out_rdy (res_rdy)
  );

  skid_reg #(.W(FBKW)) u_fbk (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (en),
    .in_stb  (err_stb),
    .in_dat  (fbk_ext),
    .in_rdy  (fbk_in_rdy),
    .out_stb (fbk_stb),
    .out_dat (fbk_dat),
    .out_rdy (fbk_rdy)
  );

  // Errors are refused while reset is held even if training is enabled.
  assign err_rdy = reset_n && fbk_in_rdy;

endmodule

// File: tb/tb_heaviside_unit.sv
// Self-checking bench for heaviside_unit: directed cases plus randomized traffic vs a queue model.
module tb_heaviside_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en;
  logic        arg_stb;
  logic [15:0] arg_dat;
  logic        arg_rdy;
  logic        res_stb;
  logic [7:0]  res_dat;
  logic        res_rdy;
  logic        err_stb;
  logic [15:0] err_dat;
  logic        err_rdy;
  logic        fbk_stb;
  logic [15:0] fbk_dat;
  logic        fbk_rdy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  res_q[$];
  logic [15:0] fbk_q[$];

  always #5 clock = ~clock;

  heaviside_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (en),
    .arg_stb (arg_stb),
    .arg_dat (arg_dat),
    .arg_rdy (arg_rdy),
    .res_stb (res_stb),
    .res_dat (res_dat),
    .res_rdy (res_rdy),
    .err_stb (err_stb),
    .err_dat (err_dat),
    .err_rdy (err_rdy),
    .fbk_stb (fbk_stb),
    .fbk_dat (fbk_dat),
    .fbk_rdy (fbk_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: each output register is a queue holding at most one pending item.
  task automatic checkOutput();
    logic exp_arg_rdy;
    logic exp_err_rdy;
    exp_arg_rdy = (res_q.size() == 0) || res_rdy;
    exp_err_rdy = en && ((fbk_q.size() == 0) || fbk_rdy);
    check("arg_rdy", 32'(arg_rdy), 32'(exp_arg_rdy));
    check("err_rdy", 32'(err_rdy), 32'(exp_err_rdy));
    check("res_stb", 32'(res_stb), 32'(res_q.size() != 0));
    check("fbk_stb", 32'(fbk_stb), 32'(fbk_q.size() != 0));
    if (res_q.size() != 0) check("res_dat", 32'(res_dat), 32'(res_q[0]));
    if (fbk_q.size() != 0) check("fbk_dat", 32'(fbk_dat), 32'(fbk_q[0]));
  endtask

  task automatic applyStimulus(
    input  logic        a_s,
    input  logic [15:0] a_d,
    input  logic        r_r,
    input  logic        e_s,
    input  logic [15:0] e_d,
    input  logic        f_r,
    input  logic        en_v,
    output logic        a_x,
    output logic        e_x
  );
    logic r_x;
    logic f_x;
    int   ev;
    @(negedge clock);
    arg_stb = a_s; arg_dat = a_d; res_rdy = r_r;
    err_stb = e_s; err_dat = e_d; fbk_rdy = f_r; en = en_v;
    #1;
    checkOutput();
    r_x = (res_q.size() != 0) && res_rdy;
    f_x = (fbk_q.size() != 0) && fbk_rdy;
    a_x = arg_stb && ((res_q.size() == 0) || res_rdy);
    e_x = err_stb && en && ((fbk_q.size() == 0) || fbk_rdy);
    if (r_x) void'(res_q.pop_front());
    if (f_x) void'(fbk_q.pop_front());
    if (a_x) res_q.push_back((arg_dat[15] == 1'b0) ? 8'hFF : 8'h00);
    if (e_x) begin
      ev = $signed(err_dat);
      fbk_q.push_back(ev[15:0]);
    end
  endtask

  logic        ax, ex;
  logic [15:0] stream_args [4];
  logic [7:0]  stream_exp  [4];

  initial begin
    reset_n = 1'b0; en = 1'b1;
    arg_stb = 1'b0; arg_dat = '0; res_rdy = 1'b1;
    err_stb = 1'b0; err_dat = '0; fbk_rdy = 1'b1;
    #1;
    check("rst_res_stb", 32'(res_stb), 32'd0);
    check("rst_fbk_stb", 32'(fbk_stb), 32'd0);
    check("rst_res_dat", 32'(res_dat), 32'd0);
    check("rst_fbk_dat", 32'(fbk_dat), 32'd0);
    check("rst_arg_rdy", 32'(arg_rdy), 32'd1);
    check("rst_err_rdy", 32'(err_rdy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Case 1: training off, zero argument is "on"; the held error is refused.
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, ax, ex);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, ax, ex);
    check("c1_res_dat", 32'(res_dat), 32'h0000_00FF);
    check("c1_res_stb", 32'(res_stb), 32'd1);
    check("c1_err_rdy", 32'(err_rdy), 32'd0);

    // Case 2: negative argument is "off"; the same held error now passes through.
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, ax, ex);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    check("c2_res_dat", 32'(res_dat), 32'h0000_0000);
    check("c2_fbk_stb", 32'(fbk_stb), 32'd1);
    check("c2_fbk_dat", 32'(fbk_dat), 32'h0000_FFFF);

    // Case 3: extreme arguments.
    applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    check("c3_max_pos", 32'(res_dat), 32'h0000_00FF);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    check("c3_max_neg", 32'(res_dat), 32'h0000_0000);

    // Case 4: back-pressure keeps the result stable and blocks new arguments.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
      check("c4_hold_stb", 32'(res_stb), 32'd1);
      check("c4_hold_dat", 32'(res_dat), 32'h0000_00FF);
      check("c4_arg_rdy", 32'(arg_rdy), 32'd0);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
    check("c4_drained", 32'(res_stb), 32'd0);
    check("c4_arg_rdy1", 32'(arg_rdy), 32'd1);

    // Case 5: streaming at one result per cycle.
    stream_args[0] = 16'h0005; stream_exp[0] = 8'hFF;
    stream_args[1] = 16'hFFFD; stream_exp[1] = 8'h00;
    stream_args[2] = 16'h0000; stream_exp[2] = 8'hFF;
    stream_args[3] = 16'hFFF9; stream_exp[3] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i < 4, (i < 4) ? stream_args[i] : 16'h0000, 1'b1,
                    1'b0, 16'h0000, 1'b1, 1'b1, ax, ex);
      if (i > 0) begin
        check("c5_stb", 32'(res_stb), 32'd1);
        check("c5_dat", 32'(res_dat), 32'(stream_exp[i-1]));
      end
    end

    // Case 6: reset with both outputs pending clears them at once.
    applyStimulus(1'b1, 16'h0005, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, ax, ex);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, ax, ex);
    check("c6_fbk_min", 32'(fbk_dat), 32'h0000_8000);
    check("c6_pre_stb", 32'({res_stb, fbk_stb}), 32'd3);
    fbk_rdy = 1'b1;
    reset_n = 1'b0;
    #1;
    check("c6_res_stb", 32'(res_stb), 32'd0);
    check("c6_fbk_stb", 32'(fbk_stb), 32'd0);
    check("c6_res_dat", 32'(res_dat), 32'd0);
    check("c6_fbk_dat", 32'(fbk_dat), 32'd0);
    check("c6_arg_rdy", 32'(arg_rdy), 32'd1);
    check("c6_err_rdy", 32'(err_rdy), 32'd0);
    res_q.delete();
    fbk_q.delete();
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized traffic; a refused strobe is held with its data until it transfers.
    begin
      logic        a_pend, e_pend, a_s, e_s, en_v;
      logic [15:0] a_d, e_d;
      a_pend = 1'b0; e_pend = 1'b0; a_s = 1'b0; e_s = 1'b0;
      a_d = '0; e_d = '0; en_v = 1'b1;
      for (int n = 0; n < 600; n++) begin
        if (!a_pend) begin
          a_s = ($urandom_range(0, 9) < 6);
          case ($urandom_range(0, 5))
            0: a_d = 16'h8000;
            1: a_d = 16'h7FFF;
            2: a_d = 16'h0000;
            default: a_d = 16'($urandom);
          endcase
        end
        if (!e_pend) begin
          e_s = ($urandom_range(0, 9) < 6);
          e_d = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
        end
        if ($urandom_range(0, 9) == 0) en_v = ~en_v;
        applyStimulus(a_s, a_d, ($urandom_range(0, 3) != 0), e_s, e_d,
                      ($urandom_range(0, 3) != 0), en_v, ax, ex);
        a_pend = a_s && !ax;
        e_pend = e_s && !ex;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
